nibble_packer: RTL and testbench

NIBBLE_PACKER -- requirements
Module: nibble_packer

---
 rtl/nibble_packer_if.sv | 24 ++
 rtl/nibble_packer.sv | 135 +++++++++++++
 tb/tb_nibble_packer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_packer_if.sv
// rtl/nibble_packer_if.sv - FIFO-side and word-side signal bundle for nibble_packer
interface nibble_packer_if #(
   parameter int NIBBLES = 4,
   parameter int CW      = 3
);
   logic                   fifo_empty;
   logic [3:0]             fifo_dout;
   logic                   fifo_r_en;
   logic                   flush;
   logic [4*NIBBLES-1:0]   word_out;
   logic                   word_valid;
   logic                   word_ready;
   logic [CW-1:0]          word_nib_cnt;

   modport master (
      input  fifo_empty, fifo_dout, flush, word_ready,
      output fifo_r_en, word_out, word_valid, word_nib_cnt
   );

   modport slave (
      output fifo_empty, fifo_dout, flush, word_ready,
      input  fifo_r_en, word_out, word_valid, word_nib_cnt
   );
endinterface

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs 4-bit FIFO nibbles into W-bit words, with flush of partial words
module nibble_packer #(
   parameter int NIBBLES = 4,
   parameter int CW      = 3
) (
   input  logic            r_clk,
   input  logic            reset,
   nibble_packer_if.master bus
);
   localparam int W = 4 * NIBBLES;
   localparam logic [CW-1:0] NIB_CW   = CW'(NIBBLES);
   localparam logic [CW:0]   NIB_WIDE = (CW+1)'(NIBBLES);

   typedef enum logic [1:0] {FILL, HOLD, FLUSH} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    acc, acc_nxt, acc_cap;
   logic [CW-1:0]   cnt, cnt_nxt, cnt_cap;
   logic            pending;
   logic            flush_req, flush_req_nxt;
   logic [W-1:0]    word_out_q, word_out_nxt;
   logic            word_valid_q, word_valid_nxt;
   logic [CW-1:0]   nib_cnt_q, nib_cnt_nxt;
   logic            r_en;
   logic            of;
   logic            full_cap;

   assign of = !word_valid_q || bus.word_ready;

   // cnt + pending bounds the nibbles already committed to this word
   assign r_en = !reset && !bus.fifo_empty && (state == FILL) && !flush_req &&
                 (({1'b0, cnt} + {{CW{1'b0}}, pending}) < NIB_WIDE);

   always_comb begin
      acc_cap = acc;
      if (pending) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (cnt == CW'(i)) acc_cap[4*i +: 4] = bus.fifo_dout;
         end
      end
   end

   assign cnt_cap  = cnt + {{(CW-1){1'b0}}, pending};
   assign full_cap = pending && (cnt_cap == NIB_CW);

   always_comb begin
      state_nxt      = state;
      acc_nxt        = acc_cap;
      cnt_nxt        = cnt_cap;
      flush_req_nxt  = flush_req;
      word_out_nxt   = word_out_q;
      nib_cnt_nxt    = nib_cnt_q;
      word_valid_nxt = word_valid_q && !bus.word_ready;
      case (state)
         FILL: begin
            if (full_cap) begin
               if (of) begin
                  word_out_nxt   = acc_cap;
                  nib_cnt_nxt    = NIB_CW;
                  word_valid_nxt = 1'b1;
                  acc_nxt        = '0;
                  cnt_nxt        = '0;
               end else begin
                  state_nxt = HOLD;
               end
            end else if (bus.flush && (cnt != '0 || pending)) begin
               flush_req_nxt = 1'b1;
               state_nxt     = FLUSH;
            end
         end
         HOLD: begin
            if (of) begin
               word_out_nxt   = acc;
               nib_cnt_nxt    = NIB_CW;
               word_valid_nxt = 1'b1;
               acc_nxt        = '0;
               cnt_nxt        = '0;
               state_nxt      = FILL;
            end
         end
         FLUSH: begin
            // a late nibble that completes the word turns the flush into a normal full word
            if (full_cap) begin
               flush_req_nxt = 1'b0;
               if (of) begin
                  word_out_nxt   = acc_cap;
                  nib_cnt_nxt    = NIB_CW;
                  word_valid_nxt = 1'b1;
                  acc_nxt        = '0;
                  cnt_nxt        = '0;
                  state_nxt      = FILL;
               end else begin
                  state_nxt = HOLD;
               end
            end else if (!pending && of) begin
               word_out_nxt   = acc;
               nib_cnt_nxt    = cnt;
               word_valid_nxt = 1'b1;
               acc_nxt        = '0;
               cnt_nxt        = '0;
               flush_req_nxt  = 1'b0;
               state_nxt      = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (reset) begin
         state        <= FILL;
         acc          <= '0;
         cnt          <= '0;
         pending      <= 1'b0;
         flush_req    <= 1'b0;
         word_out_q   <= '0;
         word_valid_q <= 1'b0;
         nib_cnt_q    <= '0;
      end else begin
         state        <= state_nxt;
         acc          <= acc_nxt;
         cnt          <= cnt_nxt;
         pending      <= r_en;
         flush_req    <= flush_req_nxt;
         word_out_q   <= word_out_nxt;
         word_valid_q <= word_valid_nxt;
         nib_cnt_q    <= nib_cnt_nxt;
      end
   end

   assign bus.fifo_r_en    = r_en;
   assign bus.word_out     = word_out_q;
   assign bus.word_valid   = word_valid_q;
   assign bus.word_nib_cnt = nib_cnt_q;
endmodule

// File: tb/tb_nibble_packer.sv
// tb/tb_nibble_packer.sv - self-checking bench for nibble_packer with a nibble-stream scoreboard
module tb_nibble_packer;
   localparam int N  = 4;
   localparam int CW = 3;

   logic r_clk;
   logic reset;
   nibble_packer_if #(.NIBBLES(N), .CW(CW)) bus ();

   nibble_packer #(.NIBBLES(N), .CW(CW)) dut (
      .r_clk (r_clk),
      .reset (reset),
      .bus   (bus)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   int          tests = 0;
   int          fails = 0;
   bit          armed = 0;
   bit          pop_now = 0;
   bit          stall = 0;
   bit          hold_prev = 0;
   logic [3:0]  next_nib = '0;
   logic [3:0]  src_q[$];
   logic [3:0]  exp_q[$];
   int          flush_pend = 0;
   int          words_acc = 0;
   int          valid_cycles = 0;
   int          cur_run = 0;
   int          max_run = 0;
   int          last_cnt = 0;
   logic [15:0] last_word = '0;
   logic [15:0] prev_word = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // one clock of stimulus: inputs change just after the rising edge, return after the falling edge
   task automatic cyc(input logic rst, input logic fl, input logic rdy);
      @(posedge r_clk);
      #1;
      if (pop_now) bus.fifo_dout = next_nib;
      reset          = rst;
      bus.flush      = fl;
      bus.word_ready = rdy;
      bus.fifo_empty = (src_q.size() == 0) || stall;
      @(negedge r_clk);
      #1;
   endtask

   // scoreboard: every accepted word must be the next nibbles popped from the FIFO, first nibble lowest
   always @(negedge r_clk) begin
      if (armed) begin
         if (reset) begin
            chk("ren_in_reset", bus.fifo_r_en, 0);
            exp_q.delete();
            flush_pend = 0;
            pop_now    = 0;
            hold_prev  = 0;
            cur_run    = 0;
         end else begin
            if (hold_prev) begin
               chk("held_valid", bus.word_valid, 1);
               chk("held_stable", bus.word_out, prev_word);
            end
            if (bus.word_valid) valid_cycles++;
            if (bus.word_valid && bus.word_ready) begin
               int          k;
               logic [15:0] exp_word;
               k = int'(bus.word_nib_cnt);
               chk("nib_cnt_range", (k >= 1 && k <= N && k <= exp_q.size()), 1);
               if (k >= 1 && k <= N && k <= exp_q.size()) begin
                  exp_word = '0;
                  for (int i = 0; i < k; i++) exp_word[4*i +: 4] = exp_q[i];
                  chk("word_data", bus.word_out, exp_word);
                  if (k != N) begin
                     chk("partial_after_flush", flush_pend > 0, 1);
                     if (flush_pend > 0) flush_pend--;
                  end
                  for (int i = 0; i < k; i++) void'(exp_q.pop_front());
               end else begin
                  exp_q.delete();
               end
               words_acc++;
               last_word = bus.word_out;
               last_cnt  = k;
            end
            hold_prev = bus.word_valid && !bus.word_ready;
            prev_word = bus.word_out;
            if (bus.fifo_r_en) begin
               chk("ren_nonempty", bus.fifo_empty, 0);
               if (src_q.size() > 0) begin
                  next_nib = src_q.pop_front();
                  exp_q.push_back(next_nib);
               end
               pop_now = 1;
               cur_run++;
               if (cur_run > max_run) max_run = cur_run;
            end else begin
               pop_now = 0;
               cur_run = 0;
            end
            if (bus.flush) flush_pend++;
         end
      end
   end

   initial begin
      int w0;
      reset          = 1'b1;
      bus.flush      = 1'b0;
      bus.word_ready = 1'b0;
      bus.fifo_dout  = '0;
      bus.fifo_empty = 1'b1;
      src_q.push_back(4'hF);

      // reset with a non-empty FIFO: no reads, outputs cleared
      cyc(1, 0, 0);
      armed = 1;
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 1);
      chk("rst_word_valid", bus.word_valid, 0);
      chk("rst_word_out", bus.word_out, 16'h0000);
      chk("rst_nib_cnt", bus.word_nib_cnt, 0);

      // flush while the single read is still in flight
      w0 = words_acc;
      cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 1);
      chk("pend_flush_words", words_acc - w0, 1);
      chk("pend_flush_word", last_word, 16'h000F);
      chk("pend_flush_cnt", last_cnt, 1);

      // four nibbles, downstream always ready
      w0 = words_acc; max_run = 0; valid_cycles = 0;
      for (int i = 1; i <= 4; i++) src_q.push_back(4'(i));
      repeat (8) cyc(0, 0, 1);
      chk("full_ren_run", max_run, 4);
      chk("full_words", words_acc - w0, 1);
      chk("full_word", last_word, 16'h4321);
      chk("full_cnt", last_cnt, 4);
      chk("full_valid_cycles", valid_cycles, 1);

      // nine nibbles with backpressure: second word held internally, ninth left in FIFO
      w0 = words_acc;
      for (int i = 1; i <= 9; i++) src_q.push_back(4'(i));
      repeat (14) cyc(0, 0, 0);
      chk("bp_unread", src_q.size(), 1);
      chk("bp_ren_stopped", bus.fifo_r_en, 0);
      chk("bp_valid", bus.word_valid, 1);
      chk("bp_word", bus.word_out, 16'h4321);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("bp_second_word", bus.word_out, 16'h8765);
      chk("bp_second_valid", bus.word_valid, 1);
      repeat (4) cyc(0, 0, 1);
      cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 1);
      chk("bp_words", words_acc - w0, 3);
      chk("bp_tail_word", last_word, 16'h0009);
      chk("bp_tail_cnt", last_cnt, 1);

      // two nibbles then flush
      w0 = words_acc;
      src_q.push_back(4'hA);
      src_q.push_back(4'hB);
      repeat (4) cyc(0, 0, 1);
      cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 1);
      chk("flush2_words", words_acc - w0, 1);
      chk("flush2_word", last_word, 16'h00BA);
      chk("flush2_cnt", last_cnt, 2);

      // flush with nothing collected is ignored
      w0 = words_acc;
      cyc(0, 1, 1);
      repeat (3) cyc(0, 0, 1);
      chk("empty_flush_words", words_acc - w0, 0);
      chk("empty_flush_valid", bus.word_valid, 0);

      // reset discards a partial word
      w0 = words_acc;
      src_q.push_back(4'h1);
      src_q.push_back(4'h2);
      repeat (4) cyc(0, 0, 1);
      cyc(1, 0, 1);
      for (int i = 5; i <= 8; i++) src_q.push_back(4'(i));
      repeat (8) cyc(0, 0, 1);
      chk("rst_mid_words", words_acc - w0, 1);
      chk("rst_mid_word", last_word, 16'h8765);

      // randomized traffic, backpressure, flushes and occasional resets
      for (int c = 0; c < 4000; c++) begin
         logic rst, fl, rdy;
         if ($urandom_range(0, 3) != 0 && src_q.size() < 20) src_q.push_back(4'($urandom));
         stall = ($urandom_range(0, 4) == 0);
         rdy   = ($urandom_range(0, 2) != 0);
         fl    = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 499) == 0);
         cyc(rst, fl, rdy);
      end

      // drain everything that was popped
      stall = 0;
      for (int i = 0; i < 300; i++) begin
         if (src_q.size() == 0 && exp_q.size() == 0 && !bus.word_valid) break;
         cyc(0, (i % 6) == 3, 1);
      end
      chk("drain_src", src_q.size(), 0);
      chk("drain_exp", exp_q.size(), 0);
      chk("drain_valid", bus.word_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
